hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Producer-side companion to the EX-stage forwarding unit. Detects the hazards that forwarding cannot resolve and drives the pipeline-register write-enables and flushes.
- Hazards covered: load-use, taken branch/jump redirect, and data-memory wait states.
- Sits between the ID-stage decode and the pipeline registers.
- Holds a load-use stall FSM, a memory-wait watchdog and performance counters.

Parameters:
- LU_STALLS, 1, load-use bubbles inserted; legal values 1 or 2. Use 2 when MEM/WB forwarding is disabled.
- MEM_TIMEOUT, 64, consecutive memory-wait cycles before mem_timeout sets.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- IF_ID_RegisterRs1  in  5  rs1 of the instruction in ID.
- IF_ID_RegisterRs2  in  5  rs2 of the instruction in ID.
- IF_ID_UsesRs1  in  1  ID instruction reads rs1.
- IF_ID_UsesRs2  in  1  ID instruction reads rs2.
- ID_EX_RegisterRd  in  5  rd of the instruction in EX.
- ID_EX_MemRead  in  1  EX instruction is a load.
- EX_BranchTaken  in  1  branch/jump resolved taken in EX this cycle.
- dmem_req  in  1  MEM stage has a memory access this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  zero IF/ID on the next edge.
- ID_EX_Write  out  1  ID/EX register enable.
- ID_EX_Flush  out  1  load a bubble (all control signals 0) into ID/EX.
- EX_MEM_Write  out  1  EX/MEM register enable.
- MEM_WB_Flush  out  1  load a bubble into MEM/WB.
- mem_timeout  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  count of cycles in which PCWrite=0.
- flush_events  out  CNT_W  count of taken-branch flushes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, lu_cnt=0, wait_cnt=0.
  - mem_timeout=0, both counters 0.
  - All enables read 1 and all flushes read 0 during reset.
- Hazard terms:
  - memwait = dmem_req & ~dmem_ready.
  - lu_hit = ID_EX_MemRead & (ID_EX_RegisterRd≠0) & ((IF_ID_UsesRs1 & Rd==Rs1) | (IF_ID_UsesRs2 & Rd==Rs2)).
- Outputs are combinational from state and inputs, in this priority order:
  1. memwait:
     - PCWrite=IF_ID_Write=ID_EX_Write=EX_MEM_Write=0, MEM_WB_Flush=1.
     - All other flushes 0.
     - FSM state and lu_cnt hold.
  2. EX_BranchTaken:
     - PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1, all other writes 1.
     - FSM goes to RUN and lu_cnt clears, which aborts any load-use stall.
  3. state=LU_STALL, or state=RUN with lu_hit:
     - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
     - EX_MEM_Write=1, ID_EX_Write=1.
  4. Otherwise: all writes 1, all flushes 0.
- FSM transitions:
  - RUN→LU_STALL on lu_hit with no memwait and no branch, only when LU_STALLS=2; lu_cnt loads 1.
  - With LU_STALLS=1 the FSM stays in RUN. The bubble clears ID_EX_MemRead, so the hazard is not re-detected.
  - LU_STALL→RUN after the lu_cnt-th non-memwait cycle; total bubbles = LU_STALLS.
- Watchdog:
  - wait_cnt increments each memwait cycle and clears on any non-memwait cycle.
  - When wait_cnt reaches MEM_TIMEOUT−1 while memwait is still asserted, mem_timeout sets on that edge.
  - mem_timeout clears only on reset. The stall continues regardless.
- Counters:
  - stall_cycles +1 on each edge where PCWrite=0.
  - flush_events +1 on each edge where EX_BranchTaken is honoured (priority 2).
  - Both saturate at all-ones and never wrap.
- rd=x0 never causes a stall.
- Reset asserted mid-stall immediately returns the FSM to RUN with outputs at their reset values.

Test Plan:
- Load x5 in EX (MemRead=1, Rd=5), ID reads rs1=5, LU_STALLS=1 -> exactly 1 cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; stall_cycles=1.
- Same hazard with rs2=5 and UsesRs2=0, then with Rd=0 -> no stall, all enables 1.
- LU_STALLS=2, load-use hazard followed by EX_BranchTaken in the second stall cycle -> that cycle shows IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1; FSM back in RUN; flush_events=1.
- dmem_req=1 with dmem_ready low for 3 cycles during a load-use stall -> 3 cycles of full freeze with MEM_WB_Flush=1, then the remaining load-use bubble resumes; stall_cycles counts all frozen cycles.
- MEM_TIMEOUT=4, memwait held for 4 cycles -> mem_timeout rises after the 4th edge and stays 1 after dmem_ready; rst_n pulse clears it.
- Preload stall_cycles near all-ones via a long memwait with CNT_W=4 -> holds at 15 and does not wrap.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Purpose: resolves load-use, taken-branch and data-memory-wait hazards by driving pipeline enables/flushes.
// Latency: enables/flushes are combinational from the current state and inputs; FSM, watchdog and counters update on each edge.
// Backpressure: a memory wait freezes every stage up to EX/MEM and bubbles MEM/WB, and it overrides branch and load-use handling.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   IF_ID_RegisterRs1/Rs2, UsesRs1/2   source registers of the instruction in ID
//   ID_EX_RegisterRd, ID_EX_MemRead    destination and load flag of the instruction in EX
//   EX_BranchTaken                     taken redirect resolved in EX
//   dmem_req, dmem_ready               MEM-stage access handshake
//   PCWrite .. MEM_WB_Flush            pipeline register enables and flushes
//   mem_timeout                        sticky watchdog error
//   stall_cycles, flush_events         saturating performance counters
module hazard_stall_unit #(
   parameter int LU_STALLS   = 1,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IF_ID_RegisterRs1,
   input  logic [4:0]       IF_ID_RegisterRs2,
   input  logic             IF_ID_UsesRs1,
   input  logic             IF_ID_UsesRs2,
   input  logic [4:0]       ID_EX_RegisterRd,
   input  logic             ID_EX_MemRead,
   input  logic             EX_BranchTaken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Write,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_Write,
   output logic             MEM_WB_Flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

   typedef enum logic [0:0] {RUN = 1'b0, LU_STALL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [1:0]       lu_cnt_q, lu_cnt_d;
   logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_events_q, flush_events_d;

   logic memwait;
   logic lu_hit;
   logic branch_fire;

   assign memwait = dmem_req & ~dmem_ready;
   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign lu_hit  = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) &&
                    ((IF_ID_UsesRs1 && (ID_EX_RegisterRd == IF_ID_RegisterRs1)) ||
                     (IF_ID_UsesRs2 && (ID_EX_RegisterRd == IF_ID_RegisterRs2)));
   assign branch_fire = ~memwait & EX_BranchTaken;

   always_comb begin
      state_d      = state_q;
      lu_cnt_d     = lu_cnt_q;
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Write  = 1'b1;
      ID_EX_Flush  = 1'b0;
      EX_MEM_Write = 1'b1;
      MEM_WB_Flush = 1'b0;
      if (memwait) begin
         // Full freeze; the load-use FSM holds so its remaining bubbles resume afterwards.
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         EX_MEM_Write = 1'b0;
         MEM_WB_Flush = 1'b1;
      end else if (EX_BranchTaken) begin
         // The redirect squashes the stalled instruction, so any pending bubbles are moot.
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
         state_d     = RUN;
         lu_cnt_d    = 2'd0;
      end else if ((state_q == LU_STALL) || lu_hit) begin
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Flush = 1'b1;
         if (state_q == RUN) begin
            // Single-bubble mode needs no state: the bubble clears ID_EX_MemRead.
            if (LU_STALLS == 2) begin
               state_d  = LU_STALL;
               lu_cnt_d = 2'(LU_STALLS - 1);
            end
         end else if (lu_cnt_q <= 2'd1) begin
            state_d  = RUN;
            lu_cnt_d = 2'd0;
         end else begin
            lu_cnt_d = lu_cnt_q - 2'd1;
         end
      end
      // Enables read 1 and flushes 0 while reset is held.
      if (!rst_n) begin
         PCWrite      = 1'b1;
         IF_ID_Write  = 1'b1;
         IF_ID_Flush  = 1'b0;
         ID_EX_Write  = 1'b1;
         ID_EX_Flush  = 1'b0;
         EX_MEM_Write = 1'b1;
         MEM_WB_Flush = 1'b0;
      end
   end

   always_comb begin
      wait_cnt_d    = '0;
      mem_timeout_d = mem_timeout_q;
      if (memwait) begin
         if (wait_cnt_q == WAIT_LAST) mem_timeout_d = 1'b1;
         else                         wait_cnt_d    = wait_cnt_q + 1'b1;
         if (wait_cnt_q == WAIT_LAST) wait_cnt_d    = wait_cnt_q;
      end
      stall_cycles_d = stall_cycles_q;
      if (!PCWrite && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
      flush_events_d = flush_events_q;
      if (branch_fire && (flush_events_q != '1)) flush_events_d = flush_events_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RUN;
         lu_cnt_q       <= 2'd0;
         wait_cnt_q     <= '0;
         mem_timeout_q  <= 1'b0;
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         state_q        <= state_d;
         lu_cnt_q       <= lu_cnt_d;
         wait_cnt_q     <= wait_cnt_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Purpose: self-checking bench for hazard_stall_unit with two configurations sharing one stimulus stream.
// Latency: control vectors sampled at the falling edge; counters checked one step after the rising edge.
// Backpressure: n/a (bench drives every input directly).
module tb_hazard_stall_unit;

   logic clk;
   logic rst_n;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, mr, br, req, rdy;

   // Control vector order: PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush
   localparam logic [6:0] RUNV = 7'b1101010;
   localparam logic [6:0] LUS  = 7'b0001110;
   localparam logic [6:0] BRV  = 7'b1111110;
   localparam logic [6:0] MWV  = 7'b0000001;

   // a: LU_STALLS=1, MEM_TIMEOUT=4, CNT_W=4.  b: LU_STALLS=2, MEM_TIMEOUT=64, CNT_W=32.
   logic        a_pcw, a_ifw, a_iff, a_idw, a_idf, a_exw, a_mwf, a_to;
   logic [3:0]  a_stall, a_flush;
   logic        b_pcw, b_ifw, b_iff, b_idw, b_idf, b_exw, b_mwf, b_to;
   logic [31:0] b_stall, b_flush;
   logic [6:0]  ctl_a, ctl_b;

   assign ctl_a = {a_pcw, a_ifw, a_iff, a_idw, a_idf, a_exw, a_mwf};
   assign ctl_b = {b_pcw, b_ifw, b_iff, b_idw, b_idf, b_exw, b_mwf};

   hazard_stall_unit #(.LU_STALLS(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2),
      .IF_ID_UsesRs1(u1), .IF_ID_UsesRs2(u2),
      .ID_EX_RegisterRd(rd), .ID_EX_MemRead(mr), .EX_BranchTaken(br),
      .dmem_req(req), .dmem_ready(rdy),
      .PCWrite(a_pcw), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_iff),
      .ID_EX_Write(a_idw), .ID_EX_Flush(a_idf), .EX_MEM_Write(a_exw),
      .MEM_WB_Flush(a_mwf), .mem_timeout(a_to),
      .stall_cycles(a_stall), .flush_events(a_flush));

   hazard_stall_unit #(.LU_STALLS(2), .MEM_TIMEOUT(64), .CNT_W(32)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2),
      .IF_ID_UsesRs1(u1), .IF_ID_UsesRs2(u2),
      .ID_EX_RegisterRd(rd), .ID_EX_MemRead(mr), .EX_BranchTaken(br),
      .dmem_req(req), .dmem_ready(rdy),
      .PCWrite(b_pcw), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_iff),
      .ID_EX_Write(b_idw), .ID_EX_Flush(b_idf), .EX_MEM_Write(b_exw),
      .MEM_WB_Flush(b_mwf), .mem_timeout(b_to),
      .stall_cycles(b_stall), .flush_events(b_flush));

   int total = 0;
   int bad   = 0;
   logic [13:0] exp_q[$];
   logic [13:0] obs_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1);
   end

   // One pipeline cycle: drive inputs, push expected {ctl_a, ctl_b}, capture observed at the falling edge.
   task automatic cyc(input logic m, input logic [4:0] d, input logic [4:0] s1, input logic us1,
                      input logic [4:0] s2, input logic us2, input logic b, input logic rq,
                      input logic ry, input logic [6:0] ea, input logic [6:0] eb);
      mr = m; rd = d; rs1 = s1; u1 = us1; rs2 = s2; u2 = us2; br = b; req = rq; rdy = ry;
      exp_q.push_back({ea, eb});
      @(negedge clk);
      obs_q.push_back({ctl_a, ctl_b});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mr = 0; rd = 0; rs1 = 0; u1 = 0; rs2 = 0; u2 = 0; br = 0; req = 0; rdy = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      // Hazards present while reset is held must not affect the outputs.
      mr = 1; rd = 5; rs1 = 5; u1 = 1; rs2 = 0; u2 = 0; br = 0; req = 1; rdy = 0;
      #12;
      total++; if (ctl_a !== RUNV) begin bad++; $display("FAIL reset_ctl_a got=%b exp=%b", ctl_a, RUNV); end
      total++; if (ctl_b !== RUNV) begin bad++; $display("FAIL reset_ctl_b got=%b exp=%b", ctl_b, RUNV); end
      total++; if ({a_to, a_stall, a_flush} !== 9'd0) begin bad++; $display("FAIL reset_state_a got=%b exp=0", {a_to, a_stall, a_flush}); end
      total++; if ({b_to, b_stall, b_flush} !== 65'd0) begin bad++; $display("FAIL reset_state_b got=%0d/%0d/%0d exp=0/0/0", b_to, b_stall, b_flush); end
      idle_inputs();
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_load_use();
      logic [13:0] e, o;
      do_reset();
      cyc(1, 5, 5, 1, 0, 0, 0, 0, 0, LUS, LUS);
      cyc(0, 0, 5, 1, 0, 0, 0, 0, 0, RUNV, LUS);   // bubble in EX; only the 2-stall config still stalls
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, RUNV);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL load_use_ctl got=%b exp=%b", o, e); end
      end
      total++; if (a_stall !== 4'd1) begin bad++; $display("FAIL load_use_stall_a got=%0d exp=1", a_stall); end
      total++; if (b_stall !== 32'd2) begin bad++; $display("FAIL load_use_stall_b got=%0d exp=2", b_stall); end
   endtask

   task automatic test_no_hazard();
      logic [13:0] e, o;
      do_reset();
      cyc(1, 5, 3, 1, 5, 0, 0, 0, 0, RUNV, RUNV);  // rs2 matches but is unused
      cyc(1, 0, 0, 1, 0, 1, 0, 0, 0, RUNV, RUNV);  // load to x0
      cyc(0, 7, 7, 1, 7, 1, 0, 0, 0, RUNV, RUNV);  // match but not a load
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL no_hazard_ctl got=%b exp=%b", o, e); end
      end
      total++; if (b_stall !== 32'd0) begin bad++; $display("FAIL no_hazard_stall got=%0d exp=0", b_stall); end
   endtask

   task automatic test_branch_abort();
      logic [13:0] e, o;
      do_reset();
      cyc(1, 9, 0, 0, 9, 1, 0, 0, 0, LUS, LUS);
      cyc(0, 0, 0, 0, 9, 1, 1, 0, 0, BRV, BRV);
      cyc(0, 0, 9, 1, 9, 1, 0, 0, 0, RUNV, RUNV);  // FSM back in RUN
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL branch_ctl got=%b exp=%b", o, e); end
      end
      total++; if (b_flush !== 32'd1) begin bad++; $display("FAIL branch_flush_b got=%0d exp=1", b_flush); end
      total++; if (a_flush !== 4'd1) begin bad++; $display("FAIL branch_flush_a got=%0d exp=1", a_flush); end
      total++; if (b_stall !== 32'd1) begin bad++; $display("FAIL branch_stall_b got=%0d exp=1", b_stall); end
   endtask

   task automatic test_memwait_in_stall();
      logic [13:0] e, o;
      do_reset();
      cyc(1, 5, 5, 1, 0, 0, 0, 0, 0, LUS, LUS);
      for (int i = 0; i < 3; i++) cyc(0, 0, 5, 1, 0, 0, 1, 1, 0, MWV, MWV);  // branch masked by memwait
      cyc(0, 0, 5, 1, 0, 0, 0, 1, 1, RUNV, LUS);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, RUNV);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL memwait_ctl got=%b exp=%b", o, e); end
      end
      total++; if (b_stall !== 32'd5) begin bad++; $display("FAIL memwait_stall_b got=%0d exp=5", b_stall); end
      total++; if (a_stall !== 4'd4) begin bad++; $display("FAIL memwait_stall_a got=%0d exp=4", a_stall); end
      total++; if (b_flush !== 32'd0) begin bad++; $display("FAIL memwait_flush_b got=%0d exp=0", b_flush); end
      total++; if (a_to !== 1'b0) begin bad++; $display("FAIL memwait_timeout_a got=%b exp=0", a_to); end
   endtask

   task automatic test_timeout();
      logic [13:0] e, o;
      do_reset();
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, MWV, MWV);
      total++; if (a_to !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", a_to); end
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, MWV, MWV);
      total++; if (a_to !== 1'b1) begin bad++; $display("FAIL timeout_set got=%b exp=1", a_to); end
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV);
      total++; if (a_to !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", a_to); end
      total++; if (b_to !== 1'b0) begin bad++; $display("FAIL timeout_b got=%b exp=0", b_to); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL timeout_ctl got=%b exp=%b", o, e); end
      end
      do_reset();
      total++; if (a_to !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b exp=0", a_to); end
   endtask

   task automatic test_saturation();
      logic [13:0] e, o;
      do_reset();
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, MWV, MWV);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL sat_ctl got=%b exp=%b", o, e); end
      end
      total++; if (a_stall !== 4'd15) begin bad++; $display("FAIL sat_stall_a got=%0d exp=15", a_stall); end
      total++; if (b_stall !== 32'd20) begin bad++; $display("FAIL sat_stall_b got=%0d exp=20", b_stall); end
   endtask

   task automatic test_reset_mid_stall();
      logic [13:0] e, o;
      do_reset();
      cyc(1, 5, 5, 1, 0, 0, 0, 0, 0, LUS, LUS);
      mr = 0; rd = 0;
      #2;
      total++; if (ctl_b !== LUS) begin bad++; $display("FAIL midrst_pre got=%b exp=%b", ctl_b, LUS); end
      rst_n = 1'b0;
      #1;
      total++; if (ctl_b !== RUNV) begin bad++; $display("FAIL midrst_out got=%b exp=%b", ctl_b, RUNV); end
      total++; if (b_stall !== 32'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", b_stall); end
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(0, 0, 5, 1, 0, 0, 0, 0, 0, RUNV, RUNV);   // FSM restarted in RUN
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL midrst_ctl got=%b exp=%b", o, e); end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_load_use();
      test_no_hazard();
      test_branch_abort();
      test_memwait_in_stall();
      test_timeout();
      test_saturation();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
